// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - MIPS fetch program counter with branch/jump/JR targets and optional delay slot
module pc_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0040_0000,
    parameter logic [31:0] EXC_VECTOR   = 32'h8000_0180,
    parameter int          DELAY_SLOT   = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_imm,
    input  logic        jump,
    input  logic [25:0] jump_target,
    input  logic        jump_reg,
    input  logic [31:0] reg_target,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        delay_pending,
    output logic        addr_err
);

    typedef enum logic {
        IDLE = 1'b0,
        SLOT = 1'b1
    } state_t;

    state_t      state;
    logic [31:0] pend_target;
    logic [31:0] branch_tgt;
    logic [31:0] jump_tgt;
    logic [31:0] redirect_tgt;
    logic        redirect;
    logic        jr_misaligned;

    assign pc_plus4      = pc + 32'd4;
    assign branch_tgt    = pc_plus4 + {{14{branch_imm[15]}}, branch_imm, 2'b00};
    assign jump_tgt      = {pc_plus4[31:28], jump_target, 2'b00};
    assign redirect      = jump_reg | jump | branch_taken;
    assign jr_misaligned = jump_reg && (reg_target[1:0] != 2'b00);

    // jump_reg outranks jump, which outranks a conditional branch
    always_comb begin
        redirect_tgt = branch_tgt;
        if (jump_reg) begin
            redirect_tgt = reg_target;
        end else if (jump) begin
            redirect_tgt = jump_tgt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc            <= RESET_VECTOR;
            state         <= IDLE;
            delay_pending <= 1'b0;
            addr_err      <= 1'b0;
            pend_target   <= 32'd0;
        end else begin
            addr_err <= 1'b0;
            if (!stall) begin
                if (jr_misaligned) begin
                    // Trap bypasses the delay slot and drops any captured redirect
                    pc            <= EXC_VECTOR;
                    addr_err      <= 1'b1;
                    state         <= IDLE;
                    delay_pending <= 1'b0;
                    pend_target   <= 32'd0;
                end else if (DELAY_SLOT == 0) begin
                    pc <= redirect ? redirect_tgt : pc_plus4;
                end else begin
                    case (state)
                        IDLE: begin
                            pc <= pc_plus4;
                            if (redirect) begin
                                pend_target   <= redirect_tgt;
                                state         <= SLOT;
                                delay_pending <= 1'b1;
                            end
                        end
                        SLOT: begin
                            // Redirects seen in the slot itself are discarded
                            pc            <= pend_target;
                            state         <= IDLE;
                            delay_pending <= 1'b0;
                        end
                        default: begin
                            pc            <= pc_plus4;
                            state         <= IDLE;
                            delay_pending <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - self-checking bench for pc_unit in both delay-slot modes
module tb_pc_unit;

    localparam logic [31:0] RV = 32'h0040_0000;
    localparam logic [31:0] EV = 32'h8000_0180;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [15:0] branch_imm = 16'd0;
    logic        jump = 1'b0;
    logic [25:0] jump_target = 26'd0;
    logic        jump_reg = 1'b0;
    logic [31:0] reg_target = 32'd0;

    logic [31:0] pc0, pc1, pp0, pp1;
    logic        dp0, dp1, ae0, ae1;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] m_pc  [2];
    logic [31:0] m_tgt [2];
    logic        m_pend[2];
    logic        m_err [2];

    always #5 clk = ~clk;

    pc_unit #(.RESET_VECTOR(RV), .EXC_VECTOR(EV), .DELAY_SLOT(0)) u0 (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .branch_taken(branch_taken), .branch_imm(branch_imm),
        .jump(jump), .jump_target(jump_target),
        .jump_reg(jump_reg), .reg_target(reg_target),
        .pc(pc0), .pc_plus4(pp0), .delay_pending(dp0), .addr_err(ae0)
    );

    pc_unit #(.RESET_VECTOR(RV), .EXC_VECTOR(EV), .DELAY_SLOT(1)) u1 (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .branch_taken(branch_taken), .branch_imm(branch_imm),
        .jump(jump), .jump_target(jump_target),
        .jump_reg(jump_reg), .reg_target(reg_target),
        .pc(pc1), .pc_plus4(pp1), .delay_pending(dp1), .addr_err(ae1)
    );

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_pc[k]   = RV;
            m_tgt[k]  = 32'd0;
            m_pend[k] = 1'b0;
            m_err[k]  = 1'b0;
        end
    endtask

    task automatic clear_inputs();
        stall = 1'b0; branch_taken = 1'b0; branch_imm = 16'd0;
        jump = 1'b0; jump_target = 26'd0; jump_reg = 1'b0; reg_target = 32'd0;
    endtask

    // Pulse reset away from the clock edge; caller is 1 time unit after a posedge
    task automatic apply_reset();
        rst_n = 1'b0;
        #2;
        model_reset();
        rst_n = 1'b1;
    endtask

    // Advance one clock: the model computes the next state from the spec's rules
    task automatic tick();
        logic [31:0] seq, tgt;
        logic [31:0] n_pc [2];
        logic [31:0] n_tgt[2];
        logic        n_pend[2];
        logic        n_err[2];
        logic        redir;
        redir = jump_reg | jump | branch_taken;
        for (int k = 0; k < 2; k++) begin
            seq = m_pc[k] + 32'd4;
            if (jump_reg)
                tgt = reg_target;
            else if (jump)
                tgt = (seq & 32'hF000_0000) | (32'(jump_target) * 32'd4);
            else
                tgt = seq + 32'($signed(branch_imm) * 4);
            n_pc[k] = m_pc[k]; n_tgt[k] = m_tgt[k]; n_pend[k] = m_pend[k]; n_err[k] = 1'b0;
            if (!stall) begin
                if (jump_reg && (reg_target % 4 != 0)) begin
                    n_pc[k] = EV; n_err[k] = 1'b1; n_pend[k] = 1'b0; n_tgt[k] = 32'd0;
                end else if (k == 0) begin
                    n_pc[k] = redir ? tgt : seq;
                end else if (m_pend[k]) begin
                    n_pc[k] = m_tgt[k]; n_pend[k] = 1'b0;
                end else begin
                    n_pc[k] = seq;
                    if (redir) begin
                        n_tgt[k] = tgt; n_pend[k] = 1'b1;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            m_pc[k] = n_pc[k]; m_tgt[k] = n_tgt[k]; m_pend[k] = n_pend[k]; m_err[k] = n_err[k];
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        #12;
        model_reset();
        n_cmp++;
        if (pc0 !== RV || pc1 !== RV) begin
            n_bad++; $display("FAIL reset_pc got=%h/%h exp=%h", pc0, pc1, RV);
        end
        n_cmp++;
        if ({dp0, dp1, ae0, ae1} !== 4'b0000) begin
            n_bad++; $display("FAIL reset_flags got=%b exp=0000", {dp0, dp1, ae0, ae1});
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            n_cmp++;
            if (pc0 !== RV + 32'(4 * i) || pp0 !== RV + 32'(4 * i + 4) || dp0 !== 1'b0) begin
                n_bad++; $display("FAIL seq_pc%0d got=%h/%h/%b exp=%h", i, pc0, pp0, dp0, RV + 32'(4 * i));
            end
        end
        #3;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (pc0 !== RV || pc1 !== RV) begin
            n_bad++; $display("FAIL async_reset got=%h/%h exp=%h", pc0, pc1, RV);
        end
        model_reset();
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_branch();
        tick(); apply_reset(); tick(); tick();
        branch_taken = 1'b1; branch_imm = 16'hFFFF;
        tick();
        n_cmp++;
        if (pc0 !== 32'h0040_0008) begin
            n_bad++; $display("FAIL branch_self got=%h exp=00400008", pc0);
        end
        branch_imm = 16'h0004;
        tick();
        n_cmp++;
        if (pc0 !== 32'h0040_001C) begin
            n_bad++; $display("FAIL branch_fwd got=%h exp=0040001c", pc0);
        end
        clear_inputs();
    endtask

    task automatic test_jump();
        apply_reset();
        for (int i = 0; i < 4; i++) tick();
        jump = 1'b1; jump_target = 26'h0100040; branch_taken = 1'b1; branch_imm = 16'h0010;
        tick();
        n_cmp++;
        if (pc0 !== 32'h0040_0100) begin
            n_bad++; $display("FAIL jump_prio got=%h exp=00400100", pc0);
        end
        jump_reg = 1'b1; reg_target = 32'h0040_0200;
        tick();
        n_cmp++;
        if (pc0 !== 32'h0040_0200) begin
            n_bad++; $display("FAIL jr_prio got=%h exp=00400200", pc0);
        end
        clear_inputs();
    endtask

    task automatic test_misaligned();
        logic [31:0] held;
        jump_reg = 1'b1; reg_target = 32'h0040_0006;
        tick();
        n_cmp++;
        if (pc0 !== EV || pc1 !== EV || ae0 !== 1'b1 || ae1 !== 1'b1 || dp1 !== 1'b0) begin
            n_bad++; $display("FAIL jr_trap got=%h/%h err=%b%b dp=%b exp=%h err=11 dp=0", pc0, pc1, ae0, ae1, dp1, EV);
        end
        clear_inputs();
        tick();
        n_cmp++;
        if (ae0 !== 1'b0 || ae1 !== 1'b0 || pc0 !== EV + 32'd4) begin
            n_bad++; $display("FAIL trap_pulse got=%b%b pc=%h exp=00 pc=%h", ae0, ae1, pc0, EV + 32'd4);
        end
        held = pc0;
        stall = 1'b1; jump_reg = 1'b1; reg_target = 32'h0040_0006;
        tick();
        n_cmp++;
        if (pc0 !== held || ae0 !== 1'b0 || ae1 !== 1'b0) begin
            n_bad++; $display("FAIL trap_stalled got=%h err=%b%b exp=%h err=00", pc0, ae0, ae1, held);
        end
        clear_inputs();
    endtask

    task automatic test_delay_slot();
        for (int pass = 0; pass < 3; pass++) begin
            apply_reset();
            branch_taken = 1'b1; branch_imm = 16'h0004;
            tick();
            clear_inputs();
            n_cmp++;
            if (pc1 !== 32'h0040_0004 || dp1 !== 1'b1) begin
                n_bad++; $display("FAIL ds_slot%0d got=%h dp=%b exp=00400004 dp=1", pass, pc1, dp1);
            end
            if (pass == 1) begin
                stall = 1'b1; tick(); tick(); stall = 1'b0;
                n_cmp++;
                if (pc1 !== 32'h0040_0004 || dp1 !== 1'b1) begin
                    n_bad++; $display("FAIL ds_stall got=%h dp=%b exp=00400004 dp=1", pc1, dp1);
                end
            end
            if (pass == 2) begin
                #3; rst_n = 1'b0; #1;
                n_cmp++;
                if (pc1 !== RV || dp1 !== 1'b0) begin
                    n_bad++; $display("FAIL ds_reset got=%h dp=%b exp=%h dp=0", pc1, dp1, RV);
                end
                model_reset(); #2; rst_n = 1'b1;
                tick();
                n_cmp++;
                if (pc1 !== RV + 32'd4 || dp1 !== 1'b0) begin
                    n_bad++; $display("FAIL ds_discard got=%h dp=%b exp=00400004 dp=0", pc1, dp1);
                end
            end else begin
                // A branch raised inside the slot must be ignored
                branch_taken = 1'b1; branch_imm = 16'h0100;
                tick();
                clear_inputs();
                n_cmp++;
                if (pc1 !== 32'h0040_0014 || dp1 !== 1'b0) begin
                    n_bad++; $display("FAIL ds_target%0d got=%h dp=%b exp=00400014 dp=0", pass, pc1, dp1);
                end
            end
        end
    endtask

    task automatic test_wrap();
        apply_reset();
        jump_reg = 1'b1; reg_target = 32'hFFFF_FFFC;
        tick();
        clear_inputs();
        n_cmp++;
        if (pc0 !== 32'hFFFF_FFFC || pp0 !== 32'd0) begin
            n_bad++; $display("FAIL wrap_p4 got=%h/%h exp=fffffffc/00000000", pc0, pp0);
        end
        tick();
        n_cmp++;
        if (pc0 !== 32'd0 || pc1 !== 32'hFFFF_FFFC) begin
            n_bad++; $display("FAIL wrap_pc got=%h/%h exp=00000000/fffffffc", pc0, pc1);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            stall        = ($urandom_range(0, 4) == 0);
            branch_taken = ($urandom_range(0, 3) == 0);
            branch_imm   = 16'($urandom);
            jump         = ($urandom_range(0, 5) == 0);
            jump_target  = 26'($urandom);
            jump_reg     = ($urandom_range(0, 6) == 0);
            reg_target   = $urandom;
            if ($urandom_range(0, 3) != 0) reg_target[1:0] = 2'b00;
            if ($urandom_range(0, 99) == 0) begin
                apply_reset();
            end
            tick();
            n_cmp++;
            if (pc0 !== m_pc[0] || pp0 !== m_pc[0] + 32'd4 || dp0 !== 1'b0 || ae0 !== m_err[0]) begin
                n_bad++; $display("FAIL rnd_ds0 cyc=%0d got=%h/%h/%b/%b exp=%h/%b", c, pc0, pp0, dp0, ae0, m_pc[0], m_err[0]);
            end
            n_cmp++;
            if (pc1 !== m_pc[1] || pp1 !== m_pc[1] + 32'd4 || dp1 !== m_pend[1] || ae1 !== m_err[1]) begin
                n_bad++; $display("FAIL rnd_ds1 cyc=%0d got=%h/%h/%b/%b exp=%h/%b/%b", c, pc1, pp1, dp1, ae1, m_pc[1], m_pend[1], m_err[1]);
            end
        end
        clear_inputs();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_branch();
        test_jump();
        test_misaligned();
        test_delay_slot();
        test_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
